mem_line_responder: RTL

MEM_LINE_RESPONDER -- requirements
Module: mem_line_responder

---
 rtl/mem_line_responder.sv | 204 ++++++++++++++++++++
 1 files changed

// File: rtl/mem_line_responder.sv
`default_nettype none
// ============================================================================
// Module   : mem_line_responder
// Purpose  : Single-outstanding memory line responder. A read or write
//            request is latched in IDLE, then completes a fixed LATENCY
//            cycles after the request first went high. Reads return a
//            128-bit line from local storage. Writes update local storage.
//            Completed reads and writes are counted with saturation.
//            Protocol violations raise a sticky error flag.
// Revision : 1.0 - initial release
// ----------------------------------------------------------------------------
// Parameters
//   LATENCY    : cycles from first request-high cycle to mem_ready (2..255)
//   DEPTH_LOG2 : log2 of the number of 128-bit storage lines (1..27)
// Ports
//   clk        in   1    clock, rising-edge active
//   rst        in   1    asynchronous reset, active low
//   mem_read   in   1    read request, held until mem_ready is seen
//   mem_write  in   1    write request, held until mem_ready is seen
//   mem_addr   in   28   line address (low DEPTH_LOG2 bits decoded)
//   mem_wdata  in   128  write line data
//   mem_ready  out  1    registered one-cycle completion pulse
//   mem_rdata  out  128  registered read data, valid with mem_ready
//   rd_count   out  16   completed reads, saturating
//   wr_count   out  16   completed writes, saturating
//   proto_err  out  1    sticky protocol-violation flag
// ============================================================================
module mem_line_responder #(
    parameter int LATENCY    = 7,
    parameter int DEPTH_LOG2 = 8
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         mem_read,
    input  logic         mem_write,
    input  logic [27:0]  mem_addr,
    input  logic [127:0] mem_wdata,
    output logic         mem_ready,
    output logic [127:0] mem_rdata,
    output logic [15:0]  rd_count,
    output logic [15:0]  wr_count,
    output logic         proto_err
);

    localparam int         c_lines    = 1 << DEPTH_LOG2;
    // The acceptance edge and the WAIT->RESP edge together account for two
    // of the LATENCY cycles, so the counter only covers the remainder.
    localparam logic [7:0] c_cnt_load = 8'(LATENCY - 2);

    localparam logic [1:0] c_idle = 2'd0;
    localparam logic [1:0] c_wait = 2'd1;
    localparam logic [1:0] c_resp = 2'd2;

    logic [1:0]            r_state;
    logic [1:0]            w_next_state;
    logic [7:0]            r_cnt;
    logic [DEPTH_LOG2-1:0] r_addr;
    logic [127:0]          r_wdata;
    logic                  r_is_write;
    logic                  r_ready;
    logic [127:0]          r_rdata;
    logic [15:0]           r_rd_count;
    logic [15:0]           r_wr_count;
    logic                  r_proto_err;
    logic [127:0]          r_mem [c_lines];

    logic                  w_req_any;
    logic                  w_req_held;
    logic                  w_accept;
    logic                  w_abort;
    logic                  w_complete;
    logic                  w_do_write;

    assign w_req_any  = mem_read | mem_write;
    // Only the request line that was latched matters while waiting; when
    // both were high at acceptance the write was chosen.
    assign w_req_held = r_is_write ? mem_write : mem_read;

    // Address bits above the decoded range alias onto the same lines.
    generate
        if (DEPTH_LOG2 < 28) begin : g_alias
            logic w_unused_upper;
            assign w_unused_upper = ^mem_addr[27:DEPTH_LOG2];
        end
    endgenerate

    // ------------------------------------------------------------------
    // State register
    // ------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state <= c_idle;
        end else begin
            r_state <= w_next_state;
        end
    end

    // ------------------------------------------------------------------
    // Next-state logic
    // ------------------------------------------------------------------
    always_comb begin
        w_next_state = r_state;
        case (r_state)
            c_idle: begin
                if (w_req_any) begin
                    w_next_state = c_wait;
                end
            end
            c_wait: begin
                if (!w_req_held) begin
                    w_next_state = c_idle;
                end else if (r_cnt == 8'd0) begin
                    w_next_state = c_resp;
                end
            end
            c_resp:  w_next_state = c_idle;
            default: w_next_state = c_idle;
        endcase
    end

    // ------------------------------------------------------------------
    // Output / control decode
    // ------------------------------------------------------------------
    always_comb begin
        w_accept   = 1'b0;
        w_abort    = 1'b0;
        w_complete = 1'b0;
        case (r_state)
            c_idle: w_accept = w_req_any;
            c_wait: begin
                w_abort    = ~w_req_held;
                w_complete = w_req_held & (r_cnt == 8'd0);
            end
            default: begin
                w_accept   = 1'b0;
            end
        endcase
    end

    assign w_do_write = w_complete & r_is_write;

    // ------------------------------------------------------------------
    // Datapath, counters and status
    // ------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_cnt       <= 8'd0;
            r_addr      <= '0;
            r_wdata     <= '0;
            r_is_write  <= 1'b0;
            r_ready     <= 1'b0;
            r_rdata     <= '0;
            r_rd_count  <= 16'd0;
            r_wr_count  <= 16'd0;
            r_proto_err <= 1'b0;
        end else begin
            r_ready <= w_complete;

            if (w_accept) begin
                r_cnt      <= c_cnt_load;
                r_addr     <= mem_addr[DEPTH_LOG2-1:0];
                r_wdata    <= mem_wdata;
                r_is_write <= mem_write;
                if (mem_read && mem_write) begin
                    r_proto_err <= 1'b1;
                end
            end else if ((r_state == c_wait) && !w_abort && (r_cnt != 8'd0)) begin
                r_cnt <= r_cnt - 8'd1;
            end

            if (w_abort) begin
                r_proto_err <= 1'b1;
            end

            if (w_complete) begin
                if (r_is_write) begin
                    if (r_wr_count != 16'hFFFF) begin
                        r_wr_count <= r_wr_count + 16'd1;
                    end
                end else begin
                    r_rdata <= r_mem[r_addr];
                    if (r_rd_count != 16'hFFFF) begin
                        r_rd_count <= r_rd_count + 16'd1;
                    end
                end
            end
        end
    end

    // Storage is deliberately not reset; its contents survive rst.
    always_ff @(posedge clk) begin
        if (w_do_write) begin
            r_mem[r_addr] <= r_wdata;
        end
    end

    assign mem_ready = r_ready;
    assign mem_rdata = r_rdata;
    assign rd_count  = r_rd_count;
    assign wr_count  = r_wr_count;
    assign proto_err = r_proto_err;

endmodule
`default_nettype wire
